// File: rtl/gpu_display_pkg.sv
// Shared display timing defaults and the scan position type used by the
// scan-out block and its timing generator.
package gpu_display_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE     = 16;
  localparam int DEF_H_TOTAL      = 20;
  localparam int DEF_V_ACTIVE     = 16;
  localparam int DEF_V_TOTAL      = 18;
  localparam int DEF_H_SYNC_START = 17;
  localparam int DEF_H_SYNC_END   = 19;
  localparam int DEF_V_SYNC_START = 16;
  localparam int DEF_V_SYNC_END   = 17;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
  } scan_pos_t;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_window(cnt_t c, cnt_t lo, cnt_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Front-buffer read port plus the buffer-flip handshake with the rasterizer.
interface framebuffer_scanout_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 1
);
  logic [ADDR_SIZE-1:0] read_addr;
  logic [DATA_SIZE-1:0] read_data;
  logic                 frame_ready;
  logic                 flip;
  logic                 flip_pending;

  modport master (
    output read_addr, flip, flip_pending,
    input  read_data, frame_ready
  );

  modport slave (
    input  read_addr, flip, flip_pending,
    output read_data, frame_ready
  );
endinterface

// File: rtl/scan_timing_gen.sv
// Raster h/v counters with active-area, sync-window and flip-point decode.
module scan_timing_gen
  import gpu_display_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_en,
  output logic active,
  output logic hsync_dec,
  output logic vsync_dec,
  output logic flip_point,
  output logic frame_wrap
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  scan_pos_t pos;
  logic      h_wrap;

  assign h_wrap     = (pos.h == H_LAST);
  assign frame_wrap = h_wrap && (pos.v == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (!scan_en) begin
      pos <= '0;
    end else begin
      pos.h <= h_wrap ? '0 : pos.h + 1'b1;
      if (h_wrap) pos.v <= (pos.v == V_LAST) ? '0 : pos.v + 1'b1;
    end
  end

  assign active     = (pos.h < cnt_t'(H_ACTIVE)) && (pos.v < cnt_t'(V_ACTIVE));
  assign hsync_dec  = in_window(pos.h, cnt_t'(H_SYNC_START), cnt_t'(H_SYNC_END));
  assign vsync_dec  = in_window(pos.v, cnt_t'(V_SYNC_START), cnt_t'(V_SYNC_END));
  // First blanking line, column 0: the only place a buffer swap may land.
  assign flip_point = scan_en && (pos.h == '0) && (pos.v == cnt_t'(V_ACTIVE));

endmodule

// File: rtl/framebuffer_scanout.sv
// Double-buffered framebuffer scan-out: walks the front buffer in raster
// order, emits pixels with syncs, and swaps buffers only in vertical blank.
module framebuffer_scanout
  import gpu_display_pkg::*;
#(
  parameter int ADDR_SIZE    = 8,
  parameter int DATA_SIZE    = 1,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  framebuffer_scanout_if.master fb,
  output logic [DATA_SIZE-1:0] pixel_out,
  output logic                 pixel_valid,
  output logic                 hsync,
  output logic                 vsync,
  output logic [7:0]           dropped_frames
);

  if (64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << ADDR_SIZE)) begin : g_bad_size
    $error("framebuffer_scanout: H_ACTIVE*V_ACTIVE exceeds address space");
  end

  logic                 active, hsync_dec, vsync_dec, flip_point, frame_wrap;
  logic                 flip_now;
  logic                 pending_q;
  logic [ADDR_SIZE-1:0] addr_q;

  scan_timing_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .H_TOTAL      (H_TOTAL),
    .V_ACTIVE     (V_ACTIVE),
    .V_TOTAL      (V_TOTAL),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_END   (H_SYNC_END),
    .V_SYNC_START (V_SYNC_START),
    .V_SYNC_END   (V_SYNC_END)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .active     (active),
    .hsync_dec  (hsync_dec),
    .vsync_dec  (vsync_dec),
    .flip_point (flip_point),
    .frame_wrap (frame_wrap)
  );

  // A request arriving exactly on the flip point is honoured that same cycle.
  assign flip_now        = flip_point && (pending_q || fb.frame_ready);
  assign fb.flip         = flip_now;
  assign fb.flip_pending = pending_q;
  assign fb.read_addr    = addr_q;

  // Incrementing address: it parks on the next line's base during hblank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      addr_q <= '0;
    else if (!scan_en || frame_wrap) addr_q <= '0;
    else if (active)              addr_q <= addr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q      <= 1'b0;
      dropped_frames <= '0;
    end else if (flip_now) begin
      // A same-cycle request behind an outstanding one queues for next frame.
      pending_q <= fb.frame_ready && pending_q;
    end else if (fb.frame_ready) begin
      if (!pending_q)                   pending_q      <= 1'b1;
      else if (dropped_frames != 8'hFF) dropped_frames <= dropped_frames + 1'b1;
    end
  end

  // One register stage matches the SRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
    end else begin
      pixel_valid <= scan_en && active;
      hsync       <= scan_en && hsync_dec;
      vsync       <= scan_en && vsync_dec;
    end
  end

  assign pixel_out = pixel_valid ? fb.read_data : '0;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a 4x3 visible / 6x5 total raster.
module tb_framebuffer_scanout;

  localparam int AW = 8, DW = 1;
  localparam int HA = 4, HT = 6, VA = 3, VT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scan_en = 1'b0;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid, hsync, vsync;
  logic [7:0]    dropped_frames;
  int            n_checks = 0;
  int            n_fail = 0;

  framebuffer_scanout_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) fb();

  framebuffer_scanout #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW),
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_SYNC_START(4), .H_SYNC_END(5), .V_SYNC_START(3), .V_SYNC_END(4)
  ) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .fb(fb.master),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .hsync(hsync), .vsync(vsync), .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  // Registered SRAM stand-in: data is the low address bit, one cycle late.
  always @(posedge clk) fb.read_data <= fb.read_addr[0];

  function automatic logic act(int k);
    return ((k % HT) < HA) && (((k / HT) % VT) < VA);
  endfunction

  function automatic int addr_of(int k);
    return ((k / HT) % VT) * HA + (k % HT);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge in cycle 0 (h=0, v=0).
  task automatic restart();
    @(negedge clk);
    rst = 1'b1; scan_en = 1'b1; fb.frame_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({fb.read_addr, fb.flip, fb.flip_pending, pixel_out, pixel_valid, hsync, vsync, dropped_frames} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got addr=%0d flip=%b pend=%b px=%b pv=%b hs=%b vs=%b drop=%0d exp all 0",
               fb.read_addr, fb.flip, fb.flip_pending, pixel_out, pixel_valid, hsync, vsync, dropped_frames);
    end
  endtask

  task automatic test_scan();
    int pv_cnt = 0;
    int a;
    logic e_pv, e_hs, e_vs, e_px;
    restart();
    for (int k = 0; k <= 30; k++) begin
      #1;
      if (k < 30 && act(k)) begin
        n_checks++;
        if (fb.read_addr !== AW'(addr_of(k))) begin
          n_fail++; $display("FAIL scan_addr cyc=%0d got=%0d exp=%0d", k, fb.read_addr, addr_of(k));
        end
      end
      if (k == 30) begin
        n_checks++;
        if (fb.read_addr !== '0) begin
          n_fail++; $display("FAIL scan_addr_wrap got=%0d exp=0", fb.read_addr);
        end
      end
      e_pv = (k > 0) && act(k - 1);
      a    = (k > 0) ? addr_of(k - 1) : 0;
      e_px = e_pv ? a[0] : 1'b0;
      e_hs = (k > 0) && ((k - 1) % HT == 4);
      e_vs = (k > 0) && (((k - 1) / HT) % VT == 3);
      if (pixel_valid) pv_cnt++;
      n_checks++;
      if ({pixel_valid, pixel_out, hsync, vsync, fb.flip} !== {e_pv, e_px, e_hs, e_vs, 1'b0}) begin
        n_fail++;
        $display("FAIL scan_out cyc=%0d got pv/px/hs/vs/flip=%b%b%b%b%b exp=%b%b%b%b0",
                 k, pixel_valid, pixel_out, hsync, vsync, fb.flip, e_pv, e_px, e_hs, e_vs);
      end
      tick();
    end
    n_checks++;
    if (pv_cnt != 12) begin
      n_fail++; $display("FAIL scan_pv_count got=%0d exp=12", pv_cnt);
    end
  endtask

  task automatic test_flip();
    restart();
    for (int k = 0; k < 30; k++) begin
      fb.frame_ready = (k == 2);
      #1;
      n_checks++;
      if ({fb.flip, fb.flip_pending} !== {k == 18, k >= 3 && k <= 18}) begin
        n_fail++;
        $display("FAIL flip_single cyc=%0d got flip=%b pend=%b exp flip=%b pend=%b",
                 k, fb.flip, fb.flip_pending, k == 18, k >= 3 && k <= 18);
      end
      tick();
    end
    fb.frame_ready = 1'b0;
  endtask

  task automatic test_drop();
    int flips = 0;
    restart();
    for (int k = 0; k < 30; k++) begin
      fb.frame_ready = (k == 2 || k == 5);
      #1;
      if (fb.flip) flips++;
      if (k == 6) begin
        n_checks++;
        if (dropped_frames !== 8'd1) begin
          n_fail++; $display("FAIL drop_first got=%0d exp=1", dropped_frames);
        end
      end
      tick();
    end
    n_checks++;
    if (flips != 1) begin
      n_fail++; $display("FAIL drop_flip_count got=%0d exp=1", flips);
    end
    // Arm a fresh request, then stop scanning so no flip point can drain it.
    fb.frame_ready = 1'b1;
    tick();
    fb.frame_ready = 1'b0;
    scan_en = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({fb.flip_pending, pixel_valid, fb.read_addr, dropped_frames} !== {1'b1, 1'b0, 8'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL drop_scan_off got pend=%b pv=%b addr=%0d drop=%0d exp pend=1 pv=0 addr=0 drop=1",
               fb.flip_pending, pixel_valid, fb.read_addr, dropped_frames);
    end
    fb.frame_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 253 || i == 254 || i == 300) begin
        n_checks++;
        if (dropped_frames !== ((i == 253) ? 8'd254 : 8'd255)) begin
          n_fail++; $display("FAIL drop_saturate after=%0d got=%0d", i, dropped_frames);
        end
      end
    end
    n_checks++;
    if (fb.flip !== 1'b0) begin
      n_fail++; $display("FAIL drop_no_flip got=%b exp=0", fb.flip);
    end
    fb.frame_ready = 1'b0;
    scan_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int flips = 0;
    restart();
    for (int k = 0; k < 60; k++) begin
      fb.frame_ready = (k == 2 || k == 18);
      #1;
      if (fb.flip) flips++;
      n_checks++;
      if ({fb.flip, fb.flip_pending} !== {k == 18 || k == 48, k >= 3 && k <= 48}) begin
        n_fail++;
        $display("FAIL queue cyc=%0d got flip=%b pend=%b exp flip=%b pend=%b",
                 k, fb.flip, fb.flip_pending, k == 18 || k == 48, k >= 3 && k <= 48);
      end
      tick();
    end
    fb.frame_ready = 1'b0;
    n_checks++;
    if (flips != 2 || dropped_frames !== 8'd0) begin
      n_fail++; $display("FAIL queue_totals got flips=%0d drop=%0d exp flips=2 drop=0", flips, dropped_frames);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int k = 0; k < 10; k++) begin
      fb.frame_ready = (k == 2);
      tick();
    end
    fb.frame_ready = 1'b0;
    #1;
    n_checks++;
    if ({fb.flip_pending, pixel_valid} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_pre got pend=%b pv=%b exp 11", fb.flip_pending, pixel_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fb.read_addr, fb.flip, fb.flip_pending, pixel_out, pixel_valid, hsync, vsync, dropped_frames} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async got addr=%0d pend=%b pv=%b px=%b exp all 0",
               fb.read_addr, fb.flip_pending, pixel_valid, pixel_out);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      n_checks++;
      if ({fb.flip, fb.flip_pending} !== 2'b00) begin
        n_fail++; $display("FAIL rst_mid_noflip cyc=%0d got flip=%b pend=%b exp 00", k, fb.flip, fb.flip_pending);
      end
      if (k < 2) begin
        n_checks++;
        if (fb.read_addr !== AW'(k)) begin
          n_fail++; $display("FAIL rst_mid_addr cyc=%0d got=%0d exp=%0d", k, fb.read_addr, k);
        end
      end
      tick();
    end
  endtask

  initial begin
    fb.frame_ready = 1'b0;
    test_reset();
    test_scan();
    test_flip();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_SIZE 8: read address width.
  DATA_SIZE 1: pixel width.
  H_ACTIVE 16, H_TOTAL 20: visible pixels per line; total clocks per line.
  V_ACTIVE 16, V_TOTAL 18: visible lines per frame; total lines per frame.
  H_SYNC_START 17, H_SYNC_END 19: hsync window on h_cnt, half-open.
  V_SYNC_START 16, V_SYNC_END 17: vsync window on v_cnt, half-open.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  scan_en  in  1  run scan; low means counters held at 0.
  frame_ready  in  1  one-cycle pulse from rasterizer: back buffer complete.
  read_data  in  DATA_SIZE  front-buffer data; registered, valid one cycle after read_addr.
  read_addr  out  ADDR_SIZE  front-buffer read address.
  flip  out  1  one-cycle pulse that swaps the double-buffered SRAM.
  flip_pending  out  1  frame_ready accepted, flip not yet issued; rasterizer must not write.
  pixel_out  out  DATA_SIZE  pixel stream.
  pixel_valid  out  1  pixel_out is an active pixel.
  hsync, vsync  out  1  active-high sync pulses, aligned with pixel_out.
  dropped_frames  out  8  saturating count of rejected frame_ready pulses.

Function
REQ-003 h_cnt counts 0..H_TOTAL-1 and wraps to 0; v_cnt increments on each h wrap and counts 0..V_TOTAL-1, wrapping to 0.
REQ-004 Counters advance only while scan_en=1; scan_en=0 synchronously forces h_cnt=v_cnt=0, read_addr=0, and all outputs except flip_pending/dropped_frames to 0.
REQ-005 active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); read_addr = v_cnt*H_ACTIVE + h_cnt during active cycles, incremented by 1 per active cycle, reset to 0 at h_cnt=0,v_cnt=0; no multiplier.
REQ-006 Read latency is exactly 1 cycle: pixel_valid, hsync, vsync are registered one cycle after the active/sync decode; pixel_out = read_data when pixel_valid=1, else 0.
REQ-007 flip_pending sets on frame_ready and clears on flip.
REQ-008 Flip point = cycle with h_cnt=0, v_cnt=V_ACTIVE (vblank start) and scan_en=1; flip=1 for exactly that cycle iff flip_pending=1 or frame_ready=1.
REQ-009 frame_ready on a flip-point cycle with flip_pending=1: flip issues, flip_pending stays 1 (new request queued), no drop.
REQ-010 frame_ready while flip_pending=1 on a non-flip-point cycle: ignored; dropped_frames increments, saturating at 255.
REQ-011 At most one flip per frame; flip never occurs during an active line.
REQ-012 Address arithmetic wraps modulo 2^ADDR_SIZE; H_ACTIVE*V_ACTIVE <= 2^ADDR_SIZE is a parameter legality rule checked by elaboration assertion.

Reset
REQ-013 rst=1 asynchronously clears h_cnt, v_cnt, read_addr, flip, flip_pending, pixel_out, pixel_valid, hsync, vsync, dropped_frames to 0.
REQ-014 Reset mid-frame abandons the frame; after release, scan restarts at h_cnt=0,v_cnt=0 on the first enabled edge; any pending flip is lost.

Structure
REQ-015 Shared package gpu_display_pkg holds default timing constants and a typedef for the (h,v) counter pair.
REQ-016 One sub-module, scan_timing_gen, owns h/v counters, active, sync and flip-point decode; the top owns address, pending/flip logic, and output pipeline.

Verification (H_ACTIVE=4, H_TOTAL=6, V_ACTIVE=3, V_TOTAL=5, syncs in blank)
REQ-017 scan_en=1 after reset -> read_addr 0,1,2,3 on line 0, 4..7 on line 1, 8..11 on line 2, returning to 0 after 30 cycles; pixel_valid is high 12 cycles/frame, each one cycle after its address.
REQ-018 read_data echoes read_addr[0] -> pixel_out sequence 0,1,0,1,... during pixel_valid and 0 elsewhere.
REQ-019 frame_ready pulse at cycle 2 -> flip_pending=1 from cycle 3; flip high only at cycle 18 (h=0,v=3); flip_pending=0 from cycle 19.
REQ-020 frame_ready at cycle 2 and cycle 5 -> dropped_frames=1; exactly one flip at cycle 18; 300 further rejected pulses -> dropped_frames=255.
REQ-021 frame_ready at cycle 18 with flip_pending=1 -> flip at 18, flip_pending still 1, second flip at cycle 48.
REQ-022 rst asserted at cycle 10 with flip pending -> all outputs 0 immediately; no flip at cycle 18; read_addr restarts at 0 after release.
